keccak_job_arbiter: RTL

- Shares one Keccak core (SHA3-256/512, SHAKE128/256) among NREQ requesters, e.g. matrix expansion, rejection samplers and the message hasher in the DILITHIUM datapath.
- Round-robin arbitration with whole-job locking: a grant holds from core start through the last squeezed block.
- Muxes absorb data to the core and steers squeeze-valids back to the granted requester.
- Sits between the requester engines and the Keccak core plus its sequencing FSM.

---
 rtl/keccak_pkg.sv | 40 ++++
 rtl/keccak_job_arbiter_rr_pick.sv | 36 +++
 rtl/keccak_job_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak job arbiter and related sequencing logic.
//   - Mode encodings used on req_mode / core_mode.
//   - Sponge rate constants (bits).
//   - Arbiter state enum.
//   - Helpers: job reject check and rate lookup.
package keccak_pkg;

    localparam logic [1:0] MODE_SHA3_256 = 2'b00;
    localparam logic [1:0] MODE_SHA3_512 = 2'b01;
    localparam logic [1:0] MODE_SHAKE128 = 2'b10;
    localparam logic [1:0] MODE_SHAKE256 = 2'b11;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;  // SHA3-256 shares this rate
    localparam int RATE_SHA3_512 = 576;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ABSORB  = 3'd2,
        ST_SQUEEZE = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

    // An XOF job asking for zero output bits can never finish a squeeze.
    function automatic logic is_reject(input logic [1:0] mode, input logic [31:0] outlen);
        return ((mode == MODE_SHAKE128) || (mode == MODE_SHAKE256)) && (outlen == 32'd0);
    endfunction

    function automatic int rate_bits(input logic [1:0] mode);
        case (mode)
            MODE_SHA3_256: rate_bits = RATE_SHAKE256;
            MODE_SHA3_512: rate_bits = RATE_SHA3_512;
            MODE_SHAKE128: rate_bits = RATE_SHAKE128;
            MODE_SHAKE256: rate_bits = RATE_SHAKE256;
            default:       rate_bits = RATE_SHAKE256;
        endcase
    endfunction

endpackage

// File: rtl/keccak_job_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : index of the last served requester
//   win_onehot : one-hot winner (first set bit scanning from ptr+1, wrapping)
//   win_idx    : winner index
//   win_valid  : any request present
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx,
    output logic            win_valid
);

    // Scan ptr+1 .. ptr+NREQ (mod NREQ); first hit wins, so ptr itself is last.
    always_comb begin
        logic [IW-1:0] idx_s;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_s = IW'((int'(ptr) + i) % NREQ);
            if (req[idx_s] && !win_valid) begin
                win_valid         = 1'b1;
                win_idx           = idx_s;
                win_onehot[idx_s] = 1'b1;
            end else begin
                win_valid = win_valid;
            end
        end
    end

endmodule

// File: rtl/keccak_job_arbiter.sv
// Shares one Keccak core among NREQ requesters with whole-job locking.
// A grant is held from core start until the job completes (last squeeze
// word, reject or watchdog timeout); the next winner is chosen round-robin.
//   req*       : per-lane job request, mode, output length, absorb stream
//   gnt        : one-hot grant (registered)
//   req_done   : one-cycle completion pulse, req_err flags reject/timeout
//   dout       : squeeze data, valid only on the granted lane
//   core_*     : start, registered mode/length, absorb stream, squeeze stream
module keccak_job_arbiter
    import keccak_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DW      = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [32*NREQ-1:0]   req_outlen,
    input  logic [DW*NREQ-1:0]   req_din,
    input  logic [NREQ-1:0]      req_din_valid,
    input  logic [NREQ-1:0]      req_din_last,
    output logic [NREQ-1:0]      req_din_ready,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      req_dout_valid,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [DW-1:0]        dout,
    output logic                 core_start,
    output logic [1:0]           core_mode,
    output logic [31:0]          core_outlen,
    output logic [DW-1:0]        core_din,
    output logic                 core_din_valid,
    output logic                 core_din_last,
    input  logic                 core_din_ready,
    input  logic [DW-1:0]        core_dout,
    input  logic                 core_dout_valid,
    input  logic                 core_dout_last
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_r, state_next_s;
    logic [IW-1:0]   ptr_r, win_r;
    logic [NREQ-1:0] gnt_r;
    logic            err_r;
    logic [1:0]      mode_r;
    logic [31:0]     outlen_r;
    logic [31:0]     wd_r;
    logic [31:0]     absorb_cnt_r;   // debug readback only

    logic [NREQ-1:0] pick_onehot_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_valid_s;
    logic            reject_s, xfer_s, sq_last_s, timeout_s;

    logic [DW-1:0]   lane_din_s    [NREQ];
    logic [1:0]      lane_mode_s   [NREQ];
    logic [31:0]     lane_outlen_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_din_s[g]    = req_din[g*DW +: DW];
        assign lane_mode_s[g]   = req_mode[g*2 +: 2];
        assign lane_outlen_s[g] = req_outlen[g*32 +: 32];
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req        (req),
        .ptr        (ptr_r),
        .win_onehot (pick_onehot_s),
        .win_idx    (pick_idx_s),
        .win_valid  (pick_valid_s)
    );

    assign reject_s  = is_reject(mode_r, outlen_r);
    assign xfer_s    = (state_r == ST_ABSORB) && req_din_valid[win_r] && core_din_ready;
    assign sq_last_s = core_dout_valid && core_dout_last;
    // A valid word in the final watchdog cycle still counts as progress.
    assign timeout_s = !core_dout_valid && (wd_r == 32'(TIMEOUT - 1));

    assign gnt         = gnt_r;
    assign core_mode   = mode_r;
    assign core_outlen = outlen_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = pick_valid_s ? ST_LOAD : ST_IDLE;
            ST_LOAD:    state_next_s = reject_s ? ST_DONE : ST_ABSORB;
            ST_ABSORB:  state_next_s = (xfer_s && req_din_last[win_r]) ? ST_SQUEEZE : ST_ABSORB;
            ST_SQUEEZE: state_next_s = (sq_last_s || timeout_s) ? ST_DONE : ST_SQUEEZE;
            ST_DONE:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: only the granted lane is ever routed.
    always_comb begin
        req_din_ready  = '0;
        req_dout_valid = '0;
        req_done       = '0;
        req_err        = '0;
        core_start     = 1'b0;
        core_din       = '0;
        core_din_valid = 1'b0;
        core_din_last  = 1'b0;
        dout           = '0;
        case (state_r)
            ST_LOAD: core_start = !reject_s;
            ST_ABSORB: begin
                core_din             = lane_din_s[win_r];
                core_din_valid       = req_din_valid[win_r];
                core_din_last        = req_din_last[win_r];
                req_din_ready[win_r] = core_din_ready;
            end
            ST_SQUEEZE: begin
                dout                  = core_dout;
                req_dout_valid[win_r] = core_dout_valid;
            end
            ST_DONE: begin
                req_done[win_r] = 1'b1;
                req_err[win_r]  = err_r;
            end
            default: core_start = 1'b0;
        endcase
    end

    // Job context: winner capture, grant, error flag, watchdog, absorb counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r        <= '0;
            win_r        <= '0;
            gnt_r        <= '0;
            err_r        <= 1'b0;
            mode_r       <= 2'b00;
            outlen_r     <= 32'd0;
            wd_r         <= 32'd0;
            absorb_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        win_r        <= pick_idx_s;
                        gnt_r        <= pick_onehot_s;
                        mode_r       <= lane_mode_s[pick_idx_s];
                        outlen_r     <= lane_outlen_s[pick_idx_s];
                        err_r        <= 1'b0;
                        absorb_cnt_r <= 32'd0;
                    end else begin
                        gnt_r <= '0;
                    end
                end
                ST_LOAD: begin
                    err_r <= reject_s;
                    wd_r  <= 32'd0;
                end
                ST_ABSORB: begin
                    wd_r <= 32'd0;
                    if (xfer_s && (absorb_cnt_r != 32'hFFFF_FFFF)) begin
                        absorb_cnt_r <= absorb_cnt_r + 32'd1;
                    end else begin
                        absorb_cnt_r <= absorb_cnt_r;
                    end
                end
                ST_SQUEEZE: begin
                    wd_r <= core_dout_valid ? 32'd0 : wd_r + 32'd1;
                    if (timeout_s) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                end
                ST_DONE: begin
                    gnt_r <= '0;
                    ptr_r <= win_r;
                end
                default: gnt_r <= '0;
            endcase
        end
    end

endmodule
